// File: rtl/vga_timing_if.sv
// Bus between the raster timing generator and the pixel/colour generator.
// The consumer side drives the run enable and reads position, sync and strobes.
interface vga_timing_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 8
);
  logic               enable;
  logic               pix_tick;
  logic [CNT_W-1:0]   hcounter;
  logic [CNT_W-1:0]   vcounter;
  logic               HS;
  logic               VS;
  logic               blank;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  enable,
    output pix_tick, hcounter, vcounter, HS, VS, blank,
           line_start, frame_start, frame_count
  );

  modport slave (
    output enable,
    input  pix_tick, hcounter, vcounter, HS, VS, blank,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: prescaled pixel step, h/v counters,
// registered sync/blank decode aligned with the counters, line/frame strobes.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 11,
  parameter int CLK_DIV   = 1,
  parameter int FRAME_W   = 8
) (
  input  logic            pixel_clk,
  input  logic            rst,
  vga_timing_if.master    bus
);
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [PW-1:0]      r_presc;
  logic [CNT_W-1:0]   r_h, r_v;
  logic [CNT_W-1:0]   w_h_nxt, w_v_nxt;
  logic               w_tick, w_h_wrap, w_v_wrap, w_frame_wrap;
  logic               r_blank, r_hs, r_vs, r_line, r_frame;
  logic [FRAME_W-1:0] r_fc;

  function automatic logic in_range(input logic [CNT_W-1:0] x, input int lo, input int hi);
    return (int'(x) >= lo) && (int'(x) < hi);
  endfunction

  assign w_tick = bus.enable && !rst && (r_presc == PRESC_LAST);

  // NOTE: every signal gets its hold value before the conditional update, so no latch is inferred.
  always_comb begin
    w_h_wrap     = (r_h == H_LAST);
    w_v_wrap     = (r_v == V_LAST);
    w_frame_wrap = w_tick && w_h_wrap && w_v_wrap;
    w_h_nxt      = r_h;
    w_v_nxt      = r_v;
    if (w_tick) begin
      w_h_nxt = w_h_wrap ? '0 : r_h + CNT_W'(1);
      if (w_h_wrap) begin
        w_v_nxt = w_v_wrap ? '0 : r_v + CNT_W'(1);
      end
    end
  end

  // Decode is taken from the next counter values so levels land with the counters.
  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_h     <= '0;
      r_v     <= '0;
      r_fc    <= '0;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
      r_blank <= 1'b0;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
    end else begin
      if (bus.enable) begin
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      end
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_line  <= w_tick && w_h_wrap;
      r_frame <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_fc <= r_fc + FRAME_W'(1);
      end
      r_blank <= !(in_range(w_h_nxt, 0, H_VISIBLE) && in_range(w_v_nxt, 0, V_VISIBLE));
      r_hs    <= in_range(w_h_nxt, HS_START, HS_START + H_SYNC) ? HS_POL : ~HS_POL;
      r_vs    <= in_range(w_v_nxt, VS_START, VS_START + V_SYNC) ? VS_POL : ~VS_POL;
    end
  end

  assign bus.pix_tick    = w_tick;
  assign bus.hcounter    = r_h;
  assign bus.vcounter    = r_v;
  assign bus.blank       = r_blank;
  assign bus.HS          = r_hs;
  assign bus.VS          = r_vs;
  assign bus.line_start  = r_line && bus.enable;
  assign bus.frame_start = r_frame && bus.enable;
  assign bus.frame_count = r_fc;
endmodule
